serial_pattern_gen: RTL

Serial bit-stream transmitter that produces the one-bit `x` input consumed by the team's serial sequence-detector FSMs. A parallel word and a bit count are accepted over a valid/ready handshake. The block shifts the selected bits out one per clock, most-significant first, then inserts a fixed idle gap before it accepts the next word. It sits upstream of the detector and drives detector stimulus both in benches and on board.

---
 rtl/serial_pattern_gen_if.sv | 25 ++
 rtl/serial_pattern_gen.sv | 103 ++++++++++
 2 files changed

// File: rtl/serial_pattern_gen_if.sv
// Word-in / bit-out bundle between a pattern source and serial_pattern_gen.
// The slave side is the generator; the master side is whoever offers words and watches x.
interface serial_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic             x;
    logic             x_valid;
    logic             done;
    logic             err;

    modport master (
        output in_valid, in_data, in_len,
        input  in_ready, x, x_valid, done, err
    );

    modport slave (
        input  in_valid, in_data, in_len,
        output in_ready, x, x_valid, done, err
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: takes a word plus bit count, shifts the low in_len bits
// out MSB-first on x, then idles GAP cycles before taking the next word.
module serial_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int GAP   = 2
) (
    input  logic clk,
    input  logic rst,
    serial_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    localparam int               GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [LEN_W-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             x_r;
    logic             x_valid_r;
    logic             done_r;
    logic             err_r;

    logic             accept;
    logic             len_ok;
    logic [WIDTH-1:0] aligned;

    assign bus.in_ready = (state == ST_IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign len_ok       = (bus.in_len != '0) && (bus.in_len <= MAX_LEN);
    // Left-justify so the first bit to send (in_data[in_len-1]) lands in the MSB.
    assign aligned      = bus.in_data << (MAX_LEN - bus.in_len);

    assign bus.x        = x_r;
    assign bus.x_valid  = x_valid_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            x_r       <= 1'b0;
            x_valid_r <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (len_ok) begin
                            x_r       <= aligned[WIDTH-1];
                            x_valid_r <= 1'b1;
                            shreg     <= aligned << 1;
                            cnt       <= bus.in_len;
                            state     <= ST_SHIFT;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    // cnt counts bits still on the wire including the one showing now.
                    if (cnt == LEN_W'(1)) begin
                        x_r       <= 1'b0;
                        x_valid_r <= 1'b0;
                        done_r    <= 1'b1;
                        shreg     <= '0;
                        cnt       <= '0;
                        if (GAP == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_cnt <= GAP_W'(GAP - 1);
                            state   <= ST_GAP;
                        end
                    end else begin
                        x_r   <= shreg[WIDTH-1];
                        shreg <= shreg << 1;
                        cnt   <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
